// File: rtl/fifo_narrow_to_wide.sv
`default_nettype none
// ============================================================================
// Module   : fifo_narrow_to_wide
// Brief    : Width-upsizing FIFO; one DATA_WIDTH word per push, the two oldest
//            words delivered together as one 2*DATA_WIDTH word per pop.
// Revision : 1.0
// ============================================================================
module fifo_narrow_to_wide #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    rd,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    empty,
    output logic                    full,
    output logic [ADDR_WIDTH:0]     count
);

    localparam int                  c_depth      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_full_count = (ADDR_WIDTH + 1)'(c_depth);
    localparam logic [ADDR_WIDTH:0] c_one        = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] c_two        = (ADDR_WIDTH + 1)'(2);

    logic [DATA_WIDTH-1:0] mem_q [c_depth];

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_r_ptr_hi;

    // Flags depend only on the registered count, so wr/rd never reach outputs
    // combinationally.
    assign empty  = (count_q < c_two);
    assign full   = (count_q == c_full_count);
    assign count  = count_q;

    assign w_push = wr && !full;
    assign w_pop  = rd && !empty;

    // r_ptr is always even and the depth is even, so the partner slot never wraps.
    assign w_r_ptr_hi = r_ptr_q + ADDR_WIDTH'(1);
    assign r_data     = {mem_q[w_r_ptr_hi], mem_q[r_ptr_q]};

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (w_push) begin
            w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
        end
        if (w_pop) begin
            r_ptr_d = r_ptr_q + ADDR_WIDTH'(2);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_one;
            2'b01:   count_d = count_q - c_two;
            2'b11:   count_d = count_q - c_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; a reset write is suppressed so discarded data stays inert.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            mem_q[w_ptr_q] <= w_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_narrow_to_wide.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_narrow_to_wide
// Brief    : Scoreboard bench; a word-queue reference model predicts pairs and
//            occupancy, a negedge monitor compares the DUT against it.
// Revision : 1.0
// ============================================================================
module tb_fifo_narrow_to_wide;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic            clk    = 1'b0;
    logic            reset  = 1'b1;
    logic            wr     = 1'b0;
    logic            rd     = 1'b0;
    logic [DW-1:0]   w_data = '0;
    logic [2*DW-1:0] r_data;
    logic            empty;
    logic            full;
    logic [AW:0]     count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0]   model[$];
    logic [2*DW-1:0] exp_q[$];
    int              ref_count = 0;
    bit              mon_en    = 1'b0;

    fifo_narrow_to_wide #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
        .r_data (r_data),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus, applied 1 time unit after a rising edge. The
    // model decides legality from its own occupancy before the edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit rst);
        bit push_ok;
        bit pop_ok;
        wr      = w;
        w_data  = d;
        rd      = r;
        reset   = rst;
        pop_ok  = !rst && r && (model.size() >= 2);
        push_ok = !rst && w && (model.size() < DEPTH);
        if (pop_ok) exp_q.push_back({model[1], model[0]});
        @(posedge clk);
        #1;
        if (rst) begin
            model.delete();
        end else begin
            if (pop_ok) begin
                void'(model.pop_front());
                void'(model.pop_front());
            end
            if (push_ok) model.push_back(d);
        end
        ref_count = model.size();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 32'(count), 32'(ref_count));
            check("empty", 32'(empty), 32'(ref_count < 2));
            check("full",  32'(full),  32'(ref_count == DEPTH));
            if (!reset && rd && !empty) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop_unexpected: got r_data 0x%0h, expected no pop at %0t", r_data, $time);
                end else begin
                    check("r_data", 32'(r_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, expected finish within 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pw;
        int pr;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Pops while empty must be ignored
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill, overfill, push+pop while full, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hAB, 1'b1, 1'b0);
        repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous push and pop with three words stored
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Incrementing stream wrapping both pointers twice
        for (int n = 0; n < 40; n++) step(1'b1, 8'(n), (n % 2) == 1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-stream with wr and rd high
        for (int n = 0; n < 5; n++) step(1'b1, 8'(8'h30 + n), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised traffic with three push/pop biases and rare resets
        for (int ph = 0; ph < 3; ph++) begin
            pw = (ph == 0) ? 80 : (ph == 1) ? 55 : 30;
            pr = (ph == 0) ? 25 : (ph == 1) ? 30 : 70;
            for (int k = 0; k < 150; k++) begin
                step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                     $urandom_range(0, 199) == 0);
            end
        end
        repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        mon_en = 1'b0;

        check("pending_pairs", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_narrow_to_wide.md
# fifo_narrow_to_wide

Width-upsizing FIFO for the homework datapath. It accepts one DATA_WIDTH word per push and delivers the two oldest words together as one 2*DATA_WIDTH word per pop. It is the counterpart of the existing wide-write / narrow-read storage path: producers here are byte-wide, and the consumer reads double-width. The block contains its own circular storage, pointer control, occupancy counter and full/empty flags.

## Interface
- DATA_WIDTH, 8, width of one pushed word; read width is 2*DATA_WIDTH
- ADDR_WIDTH, 4, storage depth is 2**ADDR_WIDTH words of DATA_WIDTH (must be ≥1)

- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clk
- wr  input  1  push request; one word per cycle
- w_data  input  DATA_WIDTH  word to push
- rd  input  1  pop request; removes two words per cycle
- r_data  output  2*DATA_WIDTH  {second-oldest word, oldest word}; oldest word in the LSBs
- empty  output  1  high when fewer than 2 words are stored, so no pop is possible
- full  output  1  high when 2**ADDR_WIDTH words are stored
- count  output  ADDR_WIDTH+1  number of stored words, 0 to 2**ADDR_WIDTH

## Operation
- State:
  - storage array mem[0 : 2**ADDR_WIDTH-1]
  - w_ptr and r_ptr, each ADDR_WIDTH bits
  - count register
- Reset clears w_ptr, r_ptr and count to 0. Storage contents are not cleared.
- Push occurs when wr && !full:
  - mem[w_ptr] <= w_data
  - w_ptr <= w_ptr+1, modulo 2**ADDR_WIDTH
- Pop occurs when rd && !empty:
  - r_ptr <= r_ptr+2, modulo 2**ADDR_WIDTH
- r_ptr is always even, because it starts at 0 and advances by 2.
- Read is asynchronous: r_data = {mem[r_ptr+1], mem[r_ptr]}.
  - r_data is don't-care while empty=1.
  - The consumer samples r_data in the same cycle it asserts rd.
- count update:
  - +1 on push only
  - −2 on pop only
  - −1 on push and pop in the same cycle
- Flags are combinational from count:
  - empty = (count < 2)
  - full = (count == 2**ADDR_WIDTH)
- A single leftover word (count=1) holds empty=1 until its partner is pushed.
- Boundary rules:
  - Push while full is ignored, even if a pop occurs in the same cycle. Nothing is written and w_ptr is unchanged.
  - Pop while empty is ignored; r_ptr and count are unchanged.
  - Simultaneous legal push and pop: both take effect. The pushed word never aliases the popped pair, because full=0 guarantees a free slot.
  - Pointers wrap silently. With ADDR_WIDTH≥1 the depth is even, so r_ptr+1 never straddles the wrap.
  - Reset asserted mid-stream wins over wr/rd in that cycle. All stored data is discarded logically.

## Timing
- Outputs after reset: count=0, empty=1, full=0, r_data=don't-care.
- Push latency: a push at edge N is reflected in count/empty/full right after edge N.
  - If that push completes a pair, r_data shows the pair in cycle N+1 (combinational read).
- Pop latency: the pair presented in cycle N is consumed at edge N+1. The next pair appears immediately after that edge if count ≥ 2.
- Throughput:
  - 1 word pushed per cycle
  - 1 pair popped per cycle
  - A steady stream sustains 1 pop every 2 cycles.
- No combinational path from wr to any output. The paths from rd to outputs are through registers only.

## Test plan
- Reset then idle → count=0, empty=1, full=0. rd=1 for 3 cycles → count stays 0, r_ptr unchanged.
- Push 0x11 → count=1, empty=1. Push 0x22 → count=2, empty=0, r_data=0x2211. Pop → count=0, empty=1.
- Push 0x00..0x0F (16 words, default params) → full=1, count=16. Push 0xAA → ignored, count=16. Eight pops return 0x0100, 0x0302, …, 0x0F0E in order.
- With count=3 (0x01, 0x02, 0x03): wr=1 with 0x04 and rd=1 in one cycle → r_data=0x0201 consumed, count=2, next r_data=0x0403.
- Wrap-around: run 40 pushes of an incrementing byte, interleaved with pops, so both pointers wrap twice. Every popped pair is {n+1, n} with no loss or duplication.
- Reset mid-stream: with count=5, assert reset with wr=rd=1 → next cycle count=0, empty=1, full=0. Then push 0x5A, 0xA5 → r_data=0xA55A.
